// File: rtl/leaf_out_arbiter_if.sv
// leaf_out_arbiter_if
//   User-side output streams feeding a leaf's BFT link arbiter.
//   Signals:
//     din_leaf_user2interface  NUM_OUT_PORTS*PAYLOAD_BITS  user words, port i at [P*i +: P]
//     vld_user2interface       NUM_OUT_PORTS               per-port word valid
//     ack_interface2user       NUM_OUT_PORTS               per-port accept (one-hot or zero)
//   Handshake: a word on port i transfers in the cycle where vld[i] and ack[i]
//   are both high. ack is combinational in the same cycle and is never high
//   while vld is low. While vld[i]=1 and ack[i]=0 the user holds its word
//   stable.
//   Modports: master = user side, slave = arbiter side.
interface leaf_out_arbiter_if #(
  parameter int NUM_OUT_PORTS = 2,
  parameter int PAYLOAD_BITS  = 32
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter
//   Credit-based round-robin scheduler sharing one BFT output link among
//   NUM_OUT_PORTS user streams. Each granted word is packed into a BFT packet
//   {valid, leaf, port, addr, credit_flag=0, payload} addressed by a
//   per-port destination table and a per-port BRAM write address counter.
//   Credit packets arriving on the BFT input replenish per-port free space.
//   Ports:
//     clk, reset                synchronous active-high reset
//     resend                    pulse: reload credits, clear addr counters and rr pointer
//     din_leaf_bft2interface    incoming BFT packets (credit packets consumed)
//     dout_leaf_interface2bft   registered outgoing packet
//     user                      user stream interface (slave modport)
//     cfg_we/cfg_port/cfg_dest_leaf/cfg_dest_port  destination table write
//     credit_overflow           sticky: a credit update saturated
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     resend,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  leaf_out_arbiter_if.slave        user,
  input  logic                     cfg_we,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  output logic                     credit_overflow
);
  localparam int N          = NUM_OUT_PORTS;
  localparam int PW         = (N > 1) ? $clog2(N) : 1;
  localparam int AW         = NUM_BRAM_ADDR_BITS;
  localparam int CW         = NUM_BRAM_ADDR_BITS + 1;
  localparam int CREDIT_MAX = 1 << AW;
  // Destination port field sits just above the credit flag and addr field.
  localparam int PORT_LSB   = PAYLOAD_BITS + 1 + AW;

  logic [NUM_LEAF_BITS-1:0] dest_leaf  [N];
  logic [NUM_PORT_BITS-1:0] dest_port  [N];
  logic [N-1:0]             dest_valid;
  logic [CW-1:0]            credit     [N];
  logic [CW-1:0]            credit_next[N];
  logic [AW-1:0]            addr       [N];
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            rr_next;

  logic [N-1:0]             eligible;
  logic [N-1:0]             grant_vec;
  logic [N-1:0]             sat_vec;
  logic                     grant_found;
  logic [PW-1:0]            grant_idx;
  logic [PAYLOAD_BITS-1:0]  grant_word;
  logic [PACKET_BITS-1:0]   grant_pkt;

  logic [NUM_PORT_BITS-1:0] cr_port;
  logic                     cr_hit;

  // Credit packets are dropped during resend (credits reload instead).
  assign cr_port = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign cr_hit  = din_leaf_bft2interface[PACKET_BITS-1] &
                   din_leaf_bft2interface[PAYLOAD_BITS] &
                   (int'(cr_port) < N) & ~resend;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = user.vld_user2interface[i] && dest_valid[i] &&
                    (credit[i] != '0) && !resend && !reset;
    end
  end

  // Round-robin search starting at rr_ptr, wrapping around.
  always_comb begin
    logic [PW-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < N; off++) begin
      cand = PW'((int'(rr_ptr) + off) % N);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_vec = '0;
    if (grant_found) grant_vec[grant_idx] = 1'b1;
    rr_next = PW'((int'(grant_idx) + 1) % N);
  end

  assign user.ack_interface2user = grant_vec;

  // Net credit change per port; saturation is applied to the net result so a
  // same-cycle grant and credit packet yields +FREESPACE_UPDATE_SIZE-1.
  always_comb begin
    int sum;
    sum     = 0;
    sat_vec = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(credit[i])
          + ((cr_hit && (int'(cr_port) == i)) ? FREESPACE_UPDATE_SIZE : 0)
          - (grant_vec[i] ? 1 : 0);
      if (sum > CREDIT_MAX) begin
        credit_next[i] = CW'(CREDIT_MAX);
        sat_vec[i]     = 1'b1;
      end else begin
        credit_next[i] = CW'(sum);
      end
    end
  end

  assign grant_word = user.din_leaf_user2interface[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign grant_pkt  = {1'b1, dest_leaf[grant_idx], dest_port[grant_idx],
                       addr[grant_idx], 1'b0, grant_word};

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_leaf_interface2bft <= '0;
      credit_overflow         <= 1'b0;
      dest_valid              <= '0;
      rr_ptr                  <= '0;
      for (int i = 0; i < N; i++) begin
        dest_leaf[i] <= '0;
        dest_port[i] <= '0;
        credit[i]    <= CW'(CREDIT_MAX);
        addr[i]      <= '0;
      end
    end else begin
      // Table writes land at the edge, so a same-cycle grant sees the old entry.
      for (int i = 0; i < N; i++) begin
        if (cfg_we && (int'(cfg_port) == i)) begin
          dest_leaf[i]  <= cfg_dest_leaf;
          dest_port[i]  <= cfg_dest_port;
          dest_valid[i] <= 1'b1;
        end
      end
      if (resend) begin
        rr_ptr <= '0;
        for (int i = 0; i < N; i++) begin
          credit[i] <= CW'(CREDIT_MAX);
          addr[i]   <= '0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          credit[i] <= credit_next[i];
          if (grant_vec[i]) addr[i] <= addr[i] + 1'b1;
        end
        if (grant_found) rr_ptr <= rr_next;
        if (|sat_vec) credit_overflow <= 1'b1;
      end
      dout_leaf_interface2bft <= grant_found ? grant_pkt : '0;
    end
  end
endmodule
